// File: rtl/mem_io_pkg.sv
// mem_io_pkg: register offsets and offset type shared by the mem_io_bridge block
package mem_io_pkg;
    typedef logic [3:0] off_t;
    localparam off_t OFF_SW       = 4'h0;
    localparam off_t OFF_KEY_EDGE = 4'h1;
    localparam off_t OFF_OUT0     = 4'h2;
    localparam off_t OFF_ALIAS    = 4'hF;
endpackage

// File: rtl/mem_io_bridge_io_sync.sv
// io_sync: 2-flop synchroniser with optional per-bit debounce (enabled by MEM_IO_DEBOUNCE_EN)
module io_sync #(
    parameter int               WIDTH           = 1,
    parameter logic [WIDTH-1:0] RST_VAL         = '0,
    parameter int               DEBOUNCE_CYCLES = 50000
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_val
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("io_sync: DEBOUNCE_CYCLES must be at least 1");
    end

    // two-flop synchroniser for the asynchronous pins
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

`ifdef MEM_IO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_cond;

    // each bit follows the synced value only after it disagrees for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cond <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync[i] == r_cond[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cond[i] <= r_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign o_val = r_cond;
`else
    assign o_val = r_sync;
`endif
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: 16-word I/O window between SLC-3 bus and SRAM (optional debounce: MEM_IO_DEBOUNCE_EN)
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 16,
    parameter logic [ADDR_W-1:0] IO_BASE         = 16'hFFF0,
    parameter int                SW_W            = 10,
    parameter int                KEY_W           = 4,
    parameter int                NUM_OUT_REGS    = 2,
    parameter int                DEBOUNCE_CYCLES = 50000
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic [ADDR_W-1:0]                ADDR,
    input  logic                             OE,
    input  logic                             WE,
    input  logic [DATA_W-1:0]                Data_from_CPU,
    input  logic [DATA_W-1:0]                Data_from_SRAM,
    input  logic [SW_W-1:0]                  Switches,
    input  logic [KEY_W-1:0]                 Keys_n,
    output logic [DATA_W-1:0]                Data_to_CPU,
    output logic [DATA_W-1:0]                Data_to_SRAM,
    output logic                             SRAM_WE,
    output logic                             IO_hit,
    output logic [NUM_OUT_REGS*DATA_W-1:0]   Out_regs
);
    off_t              w_off;
    logic              w_wr;
    logic [SW_W-1:0]   w_sw;
    logic [KEY_W-1:0]  w_key;
    logic [KEY_W-1:0]  w_press;
    logic [KEY_W-1:0]  w_clr;
    logic [KEY_W-1:0]  r_key_prev;
    logic [KEY_W-1:0]  r_key_edge;
    logic [DATA_W-1:0] r_out [NUM_OUT_REGS];
    logic [DATA_W-1:0] w_map;

    assign IO_hit       = (ADDR[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign w_off        = ADDR[3:0];
    assign w_wr         = WE & IO_hit;
    assign SRAM_WE      = WE & ~IO_hit;
    assign Data_to_SRAM = Data_from_CPU;

    io_sync #(.WIDTH(SW_W), .RST_VAL('0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_sync (
        .Clk(Clk), .Reset_n(Reset_n), .i_raw(Switches), .o_val(w_sw)
    );

    io_sync #(.WIDTH(KEY_W), .RST_VAL({KEY_W{1'b1}}), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sync (
        .Clk(Clk), .Reset_n(Reset_n), .i_raw(Keys_n), .o_val(w_key)
    );

    assign w_press = r_key_prev & ~w_key;
    assign w_clr   = (w_wr && w_off == OFF_KEY_EDGE) ? Data_from_CPU[KEY_W-1:0] : '0;

    // sticky press capture; a press in the same cycle as its clear keeps the bit set
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_key_prev <= '1;
            r_key_edge <= '0;
        end else begin
            r_key_prev <= w_key;
            r_key_edge <= (r_key_edge & ~w_clr) | w_press;
        end
    end

    // output registers take full-width writes; the top alias offset also targets OUT[0]
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_OUT_REGS; k++) r_out[k] <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_OUT_REGS; k++)
                if (w_off == off_t'(OFF_OUT0 + k) || (k == 0 && w_off == OFF_ALIAS))
                    r_out[k] <= Data_from_CPU;
        end
    end

    for (genvar g = 0; g < NUM_OUT_REGS; g++) begin : g_out
        assign Out_regs[g*DATA_W +: DATA_W] = r_out[g];
    end

    // read mux: mapped I/O value on window reads, SRAM data otherwise
    always_comb begin
        w_map = '0;
        if (w_off == OFF_SW || w_off == OFF_ALIAS) w_map = DATA_W'(w_sw);
        else if (w_off == OFF_KEY_EDGE) w_map = DATA_W'(r_key_edge);
        for (int k = 0; k < NUM_OUT_REGS; k++)
            if (w_off == off_t'(OFF_OUT0 + k)) w_map = r_out[k];
        Data_to_CPU = (OE && !WE && IO_hit) ? w_map : Data_from_SRAM;
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: randomized self-checking bench for mem_io_bridge against a delay-line reference model
module tb_mem_io_bridge;
`ifdef MEM_IO_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 2 + DB;
    localparam int NOR = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] ADDR = '0;
    logic        OE = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] Data_from_CPU = '0;
    logic [15:0] Data_from_SRAM = '0;
    logic [9:0]  Switches = '0;
    logic [3:0]  Keys_n = '1;
    logic [15:0] Data_to_CPU;
    logic [15:0] Data_to_SRAM;
    logic        SRAM_WE;
    logic        IO_hit;
    logic [31:0] Out_regs;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    mem_io_bridge #(.DEBOUNCE_CYCLES(DB > 0 ? DB : 50000)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ADDR(ADDR), .OE(OE), .WE(WE),
        .Data_from_CPU(Data_from_CPU), .Data_from_SRAM(Data_from_SRAM),
        .Switches(Switches), .Keys_n(Keys_n), .Data_to_CPU(Data_to_CPU),
        .Data_to_SRAM(Data_to_SRAM), .SRAM_WE(SRAM_WE), .IO_hit(IO_hit), .Out_regs(Out_regs)
    );

    // reference model: pins appear LAT edges later; presses are released->pressed steps of that delayed view
    logic [9:0]  sw_pipe  [LAT];
    logic [3:0]  key_pipe [LAT];
    logic [3:0]  m_prev, m_edge, m_clr;
    logic [15:0] m_out [NOR];

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                sw_pipe[i]  = '0;
                key_pipe[i] = '1;
            end
            m_prev = '1;
            m_edge = '0;
            for (int i = 0; i < NOR; i++) m_out[i] = '0;
        end else begin
            m_clr  = (WE && ADDR[15:4] == 12'hFFF && ADDR[3:0] == 4'h1) ? Data_from_CPU[3:0] : 4'h0;
            m_edge = (m_edge & ~m_clr) | (m_prev & ~key_pipe[LAT-1]);
            m_prev = key_pipe[LAT-1];
            if (WE && ADDR[15:4] == 12'hFFF) begin
                if (ADDR[3:0] == 4'hF) m_out[0] = Data_from_CPU;
                else if (ADDR[3:0] >= 4'd2 && int'(ADDR[3:0]) < 2 + NOR) m_out[ADDR[3:0] - 4'd2] = Data_from_CPU;
            end
            for (int i = LAT - 1; i > 0; i--) begin
                sw_pipe[i]  = sw_pipe[i-1];
                key_pipe[i] = key_pipe[i-1];
            end
            sw_pipe[0]  = Switches;
            key_pipe[0] = Keys_n;
        end
    end

    function automatic logic [15:0] exp_cpu();
        logic [15:0] v = 16'h0;
        if (!(OE && !WE && ADDR[15:4] == 12'hFFF)) return Data_from_SRAM;
        if (ADDR[3:0] == 4'h0 || ADDR[3:0] == 4'hF) v = {6'h0, sw_pipe[LAT-1]};
        else if (ADDR[3:0] == 4'h1) v = {12'h0, m_edge};
        else if (int'(ADDR[3:0]) < 2 + NOR) v = m_out[ADDR[3:0] - 4'd2];
        return v;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic oe, input logic we, input logic [15:0] d);
        ADDR = a;
        OE = oe;
        WE = we;
        Data_from_CPU = d;
        Data_from_SRAM = 16'($urandom);
        #1;
    endtask

    task automatic test_reset();
        Switches = 10'h3FF;
        repeat (3) tick();
        Switches = '0;
        Reset_n = 1'b1;
        tick();
        drive(16'hFFF2, 1'b0, 1'b1, 16'h5555);
        tick();
        drive(16'hFFF2, 1'b0, 1'b1, 16'h1234);
        Switches = 10'h155;
        #1 Reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (Out_regs !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out: got %h want %h", Out_regs, 32'h0);
        end
        drive(16'hFFF1, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_key_edge: got %h want %h", Data_to_CPU, 16'h0);
        end
        drive(16'hFFF0, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_sw: got %h want %h", Data_to_CPU, 16'h0);
        end
        Switches = '0;
        drive(16'h0000, 1'b0, 1'b0, 16'h0);
        Reset_n = 1'b1;
        tick();
        drive(16'hFFF2, 1'b0, 1'b1, 16'h1234);
        vectors++;
        if (SRAM_WE !== 1'b0 || IO_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL io_write_decode: got we=%b hit=%b want we=0 hit=1", SRAM_WE, IO_hit);
        end
        tick();
        vectors++;
        if (Out_regs[15:0] !== 16'h1234 || Out_regs[15:0] !== m_out[0]) begin
            miscompares++;
            $display("FAIL first_write: got %h want %h", Out_regs[15:0], 16'h1234);
        end
    endtask

    task automatic test_switches();
        Switches = 10'h2A5;
        repeat (LAT + 1) tick();
        drive(16'hFFF0, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h02A5 || Data_to_CPU !== exp_cpu()) begin
            miscompares++;
            $display("FAIL sw_read: got %h want %h", Data_to_CPU, 16'h02A5);
        end
        drive(16'hFFFF, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h02A5) begin
            miscompares++;
            $display("FAIL alias_read: got %h want %h", Data_to_CPU, 16'h02A5);
        end
        drive(16'h3000, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== Data_from_SRAM || IO_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL sram_read: got %h hit=%b want %h hit=0", Data_to_CPU, IO_hit, Data_from_SRAM);
        end
        drive(16'h3000, 1'b0, 1'b1, 16'hCAFE);
        vectors++;
        if (SRAM_WE !== 1'b1 || Data_to_SRAM !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL sram_write: got we=%b d=%h want we=1 d=cafe", SRAM_WE, Data_to_SRAM);
        end
        drive(16'h0000, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_keys();
        int sets = 0;
        logic prev_bit;
        drive(16'hFFF1, 1'b1, 1'b0, 16'h0);
        prev_bit = Data_to_CPU[2];
        Keys_n = 4'b1011;
        for (int i = 0; i < 100; i++) begin
            tick();
            vectors++;
            if (Data_to_CPU !== exp_cpu()) begin
                miscompares++;
                $display("FAIL key_hold[%0d]: got %h want %h", i, Data_to_CPU, exp_cpu());
            end
            if (Data_to_CPU[2] && !prev_bit) sets++;
            prev_bit = Data_to_CPU[2];
        end
        vectors++;
        if (sets != 1 || Data_to_CPU !== 16'h0004) begin
            miscompares++;
            $display("FAIL key_single_capture: got sets=%0d val=%h want sets=1 val=0004", sets, Data_to_CPU);
        end
        drive(16'hFFF1, 1'b0, 1'b1, 16'h0004);
        tick();
        drive(16'hFFF1, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h0000) begin
            miscompares++;
            $display("FAIL key_w1c: got %h want %h", Data_to_CPU, 16'h0);
        end
        Keys_n = '1;
        repeat (LAT + 2) tick();
        vectors++;
        if (Data_to_CPU !== 16'h0000) begin
            miscompares++;
            $display("FAIL key_release: got %h want %h", Data_to_CPU, 16'h0);
        end
    endtask

    task automatic test_w1c_race();
        tick();
        Keys_n = 4'b1101;
        repeat (LAT) tick();
        drive(16'hFFF1, 1'b0, 1'b1, 16'h0002);
        tick();
        drive(16'hFFF1, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h0002 || Data_to_CPU !== exp_cpu()) begin
            miscompares++;
            $display("FAIL w1c_race: got %h want %h", Data_to_CPU, 16'h0002);
        end
        drive(16'hFFF1, 1'b0, 1'b1, 16'h0002);
        tick();
        drive(16'hFFF1, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h0000) begin
            miscompares++;
            $display("FAIL w1c_after_race: got %h want %h", Data_to_CPU, 16'h0);
        end
        Keys_n = '1;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_out_regs();
        drive(16'hFFFF, 1'b0, 1'b1, 16'hBEEF);
        tick();
        vectors++;
        if (Out_regs[15:0] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL alias_write: got %h want %h", Out_regs[15:0], 16'hBEEF);
        end
        drive(16'hFFF3, 1'b0, 1'b1, 16'h00FF);
        tick();
        vectors++;
        if (Out_regs[31:16] !== 16'h00FF) begin
            miscompares++;
            $display("FAIL out1_write: got %h want %h", Out_regs[31:16], 16'h00FF);
        end
        drive(16'hFFF8, 1'b0, 1'b1, 16'h1111);
        tick();
        vectors++;
        if (Out_regs !== 32'h00FF_BEEF) begin
            miscompares++;
            $display("FAIL unmapped_write: got %h want %h", Out_regs, 32'h00FF_BEEF);
        end
        drive(16'hFFF8, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h0000) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h want %h", Data_to_CPU, 16'h0);
        end
        drive(16'hFFF2, 1'b0, 1'b1, 16'hA5A5);
        tick();
        drive(16'hFFF2, 1'b0, 1'b1, 16'h5A5A);
        vectors++;
        if (Out_regs[15:0] !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL b2b_first: got %h want %h", Out_regs[15:0], 16'hA5A5);
        end
        tick();
        vectors++;
        if (Out_regs[15:0] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL b2b_second: got %h want %h", Out_regs[15:0], 16'h5A5A);
        end
        drive(16'hFFF3, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h00FF) begin
            miscompares++;
            $display("FAIL out1_read: got %h want %h", Data_to_CPU, 16'h00FF);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int n = 0; n < 400; n++) begin
            if (n % 8 == 0) begin
                Switches = 10'($urandom);
                Keys_n = 4'($urandom);
            end
            a = ($urandom_range(0, 1) == 1) ? {12'hFFF, 4'($urandom)} : 16'($urandom);
            drive(a, 1'($urandom), $urandom_range(0, 3) == 0, 16'($urandom));
            vectors++;
            if (Data_to_CPU !== exp_cpu()) begin
                miscompares++;
                $display("FAIL rand_read[%0d] addr=%h: got %h want %h", n, a, Data_to_CPU, exp_cpu());
            end
            vectors++;
            if (SRAM_WE !== (WE && a[15:4] != 12'hFFF) || IO_hit !== (a[15:4] == 12'hFFF)) begin
                miscompares++;
                $display("FAIL rand_decode[%0d] addr=%h: got we=%b hit=%b", n, a, SRAM_WE, IO_hit);
            end
            tick();
            vectors++;
            if (Out_regs !== {m_out[1], m_out[0]}) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got %h want %h", n, Out_regs, {m_out[1], m_out[0]});
            end
        end
        drive(16'h0000, 1'b0, 1'b0, 16'h0);
    endtask

`ifdef MEM_IO_DEBOUNCE_EN
    task automatic test_debounce();
        Switches = 10'h0F0;
        repeat (LAT + 2) tick();
        drive(16'hFFF0, 1'b1, 1'b0, 16'h0);
        vectors++;
        if (Data_to_CPU !== 16'h00F0) begin
            miscompares++;
            $display("FAIL db_settle: got %h want %h", Data_to_CPU, 16'h00F0);
        end
        Switches = 10'h0F1;
        repeat (3) tick();
        Switches = 10'h0F0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            vectors++;
            if (Data_to_CPU !== 16'h00F0) begin
                miscompares++;
                $display("FAIL db_glitch[%0d]: got %h want %h", i, Data_to_CPU, 16'h00F0);
            end
        end
        Switches = 10'h0F3;
        repeat (LAT - 1) tick();
        vectors++;
        if (Data_to_CPU !== 16'h00F0) begin
            miscompares++;
            $display("FAIL db_early: got %h want %h", Data_to_CPU, 16'h00F0);
        end
        tick();
        vectors++;
        if (Data_to_CPU !== 16'h00F3) begin
            miscompares++;
            $display("FAIL db_update: got %h want %h", Data_to_CPU, 16'h00F3);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_switches();
        test_keys();
        test_w1c_race();
        test_out_regs();
        test_random();
`ifdef MEM_IO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
